// File: rtl/mem_pattern_checker.sv
// mem_pattern_checker: writes SEED^addr to memory, reads it back and counts mismatches/timeouts.
module mem_pattern_checker #(
  parameter int          ADDR_W     = 21,
  parameter int          DATA_W     = 32,
  parameter int          NUM_WORDS  = 1024,
  parameter logic [31:0] SEED       = 32'hA5A5_0000,
  parameter int          RD_TIMEOUT = 255
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              start,
  output logic              busy,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic              cmd_write,
  output logic [ADDR_W-1:0] cmd_addr,
  output logic [DATA_W-1:0] wr_data,
  input  logic              rd_valid,
  input  logic [DATA_W-1:0] rd_data,
  output logic [3:0]        proccess,
  output logic [31:0]       erro_read,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic              pass
);
  localparam int TW = (RD_TIMEOUT < 2) ? 1 : $clog2(RD_TIMEOUT + 1);
  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    WRITE     = 4'd1,
    READ_REQ  = 4'd2,
    READ_WAIT = 4'd3,
    DONE      = 4'd4
  } state_t;
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d, ferr_q, ferr_d;
  logic [31:0]       err_q, err_d;
  logic              pass_q, pass_d;
  logic [TW-1:0]     tmo_q, tmo_d;
  logic              last, accept, err_ev;
  function automatic logic [DATA_W-1:0] pattern(input logic [ADDR_W-1:0] a);
    return DATA_W'(SEED) ^ DATA_W'(a);
  endfunction
  assign cmd_valid      = state_q == WRITE || state_q == READ_REQ;
  assign cmd_write      = state_q == WRITE;
  assign cmd_addr       = addr_q;
  assign wr_data        = state_q == WRITE ? pattern(addr_q) : '0;
  assign busy           = cmd_valid || state_q == READ_WAIT;
  assign proccess       = state_q;
  assign erro_read      = err_q;
  assign first_err_addr = ferr_q;
  assign pass           = pass_q;
  assign last           = addr_q == ADDR_W'(NUM_WORDS - 1);
  assign accept         = cmd_valid && cmd_ready;
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    ferr_d  = ferr_q;
    err_d   = err_q;
    pass_d  = pass_q;
    tmo_d   = tmo_q;
    err_ev  = 1'b0;
    case (state_q)
      IDLE, DONE: if (start) begin
        state_d = WRITE;
        addr_d  = '0;
        err_d   = '0;
        ferr_d  = '0;
        pass_d  = 1'b0;
      end
      WRITE: if (accept) begin
        addr_d  = last ? '0 : addr_q + 1'b1;
        state_d = last ? READ_REQ : WRITE;
      end
      READ_REQ: if (accept) begin
        state_d = READ_WAIT;
        tmo_d   = '0;
      end
      READ_WAIT: begin
        tmo_d = tmo_q + 1'b1;
        // rd_valid takes priority over a coincident timeout
        if (rd_valid || tmo_q == TW'(RD_TIMEOUT - 1)) begin
          err_ev  = rd_valid ? rd_data != pattern(addr_q) : 1'b1;
          addr_d  = last ? addr_q : addr_q + 1'b1;
          state_d = last ? DONE : READ_REQ;
        end
      end
      default: state_d = IDLE;
    endcase
    if (err_ev) begin
      err_d  = &err_q ? err_q : err_q + 1'b1;
      ferr_d = err_q == '0 ? addr_q : ferr_q;
    end
    if (state_d == DONE && state_q != DONE) pass_d = err_d == '0;
  end
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      ferr_q  <= '0;
      err_q   <= '0;
      pass_q  <= 1'b0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      ferr_q  <= ferr_d;
      err_q   <= err_d;
      pass_q  <= pass_d;
      tmo_q   <= tmo_d;
    end
  end
endmodule

// File: doc/mem_pattern_checker.md
Name: mem_pattern_checker

Overview:
- Self-test engine that writes a deterministic address-derived pattern into external memory, then reads it back, compares and counts mismatches.
- Drives a generic single-outstanding command/read-data port of the memory controller.
- Its state code `proccess[3:0]` and running error count `erro_read[31:0]` are the probed signals sampled by the on-chip logic-analyzer core on `sys_clk`.

Parameters:
- `ADDR_W`, 21, memory word-address width.
- `DATA_W`, 32, memory data width (must be ≥ `ADDR_W`).
- `NUM_WORDS`, 1024, words tested, addresses 0 .. `NUM_WORDS-1`; range 1 .. 2^`ADDR_W`.
- `SEED`, 32'hA5A5_0000, pattern constant.
- `RD_TIMEOUT`, 255, max cycles waiting for `rd_valid` after read accept.

Ports:
- `sys_clk`  in  1  system clock; all logic on rising edge.
- `sys_rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle pulse; begins a test run.
- `busy`  out  1  high from run start until DONE state is entered.
- `cmd_valid`  out  1  command request to memory controller.
- `cmd_ready`  in  1  controller accepts command when `cmd_valid` and `cmd_ready` are both high.
- `cmd_write`  out  1  1 = write, 0 = read.
- `cmd_addr`  out  `ADDR_W`  word address.
- `wr_data`  out  `DATA_W`  write data; valid with `cmd_valid` && `cmd_write`.
- `rd_valid`  in  1  read data strobe, one cycle.
- `rd_data`  in  `DATA_W`  read data.
- `proccess`  out  4  current state code.
- `erro_read`  out  32  mismatch count, including timeouts.
- `first_err_addr`  out  `ADDR_W`  address of first error in the run.
- `pass`  out  1  high in DONE when `erro_read`==0.

Behaviour:
- Pattern: `pattern(a) = SEED XOR zero_extend(a)` to `DATA_W`.
- State codes on `proccess`:
  - 0 IDLE
  - 1 WRITE
  - 2 READ_REQ
  - 3 READ_WAIT
  - 4 DONE
  - 5..15 unused; if ever entered, go to IDLE.
- Reset (async assert): state IDLE and all outputs 0, i.e. `cmd_valid`=0, `busy`=0, `erro_read`=0, `first_err_addr`=0, `pass`=0. No output is driven high until the first `sys_clk` edge after `sys_rst` deasserts. Reset mid-run abandons the run; an outstanding read is discarded.
- IDLE/DONE with `start`=1:
  - clear `erro_read`, `first_err_addr`, `pass` and the address counter to 0;
  - `busy`=1; next state WRITE.
  - `start` in any other state is ignored.
- WRITE:
  - `cmd_valid`=1, `cmd_write`=1, `cmd_addr`=addr, `wr_data`=`pattern(addr)`.
  - Outputs stay stable until accepted.
  - On accept with addr=`NUM_WORDS-1`: clear addr, go to READ_REQ; otherwise addr+1.
  - Back-to-back accepts allowed: one write per cycle when `cmd_ready` is held high.
- READ_REQ:
  - `cmd_valid`=1, `cmd_write`=0, `cmd_addr`=addr.
  - On accept: go to READ_WAIT, timeout counter=0.
- READ_WAIT:
  - `cmd_valid`=0; timeout counter increments each cycle.
  - On `rd_valid`: compare `rd_data` with `pattern(addr)`; a mismatch counts as an error.
  - If the counter reaches `RD_TIMEOUT` without `rd_valid`: count as an error.
  - Either event: if addr=`NUM_WORDS-1` go to DONE; else addr+1 and go to READ_REQ.
  - `rd_valid` and timeout in the same cycle: `rd_valid` wins.
- Error counting:
  - `erro_read` increments by 1, saturating at 32'hFFFF_FFFF.
  - `first_err_addr` captures addr only on the first error of the run.
- `rd_valid` outside READ_WAIT is ignored.
- DONE: `busy`=0, `pass`=(`erro_read`==0); outputs held until the next `start`.
- Latency:
  - `start` → first write `cmd_valid`: 1 cycle.
  - `rd_valid` → updated `erro_read`/`proccess`: 1 cycle, registered.
- `NUM_WORDS`=1: one write, one read, then DONE.

Test Plan:
- `NUM_WORDS`=4, `SEED`=32'hA5A5_0000, `cmd_ready`=1, memory model echoes writes, read latency 3 → writes `data` A5A5_0000..A5A5_0003 at addresses 0..3, 4 reads; DONE: `proccess`=4, `erro_read`=0, `pass`=1, `busy`=0.
- Same run, model flips bit 0 of addr 2 read data → `erro_read`=1, `first_err_addr`=2, `pass`=0.
- Model withholds `rd_valid` for addr 1, `RD_TIMEOUT`=8 → READ_WAIT for 8 cycles, then `erro_read`=1, `first_err_addr`=1; run completes with `proccess`=4.
- `cmd_ready` toggled randomly in WRITE and READ_REQ → `cmd_addr`/`wr_data` stable while stalled; exactly 4 writes and 4 reads issued; `erro_read`=0.
- `sys_rst` pulsed during READ_WAIT, then late `rd_valid` → all outputs 0, `proccess`=0, late `rd_valid` ignored; a new `start` runs clean to `pass`=1.
- `start` pulsed during WRITE → ignored, address sequence unchanged; `start` in DONE → counters cleared, new run.
